// File: rtl/regfile_bypass_param.sv
// -----------------------------------------------------------------------------
// regfile_bypass_param
//
// Parametrised two-read / one-write register file for the 16-bit CPU datapath.
// Sits between decode (read addresses) and writeback (write port).
//
// A write is first captured into a pending stage (pend_*_reg) on one rising
// edge and committed to the array on the following edge. Capture of the next
// write and commit of the previous one share an edge, so one write per cycle
// is sustained. Reads are combinational from the address and may optionally
// be served from the pending stage (BYPASS) so that a write captured at edge N
// is visible right after edge N rather than after edge N+1.
//
// Parameters:
//   DATA_W   register width in bits
//   ADDR_W   address width; DEPTH = 2**ADDR_W registers
//   ZERO_R0  1 = R0 reads as zero and writes to address 0 are discarded
//   BYPASS   1 = reads return the pending write data on an address match
//   INIT_R0  reset value of R0 (ignored when ZERO_R0 = 1)
//   INIT_R1  reset value of R1; every other register resets to zero
//
// Ports:
//   clk         system clock, rising-edge active
//   rst_n       asynchronous active-low reset
//   rd_adr1/2   read port addresses
//   wr_adr      write address
//   wr_data     write data
//   wr_en       write request, sampled on the rising edge
//   rd_data1/2  read port data, combinational from the addresses
//   wr_pending  high while a captured write awaits commit
// -----------------------------------------------------------------------------
module regfile_bypass_param #(
   parameter int                DATA_W  = 16,
   parameter int                ADDR_W  = 3,
   parameter int                ZERO_R0 = 0,
   parameter int                BYPASS  = 1,
   parameter logic [DATA_W-1:0] INIT_R0 = DATA_W'(16'h0002),
   parameter logic [DATA_W-1:0] INIT_R1 = DATA_W'(16'h0008)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rd_adr1,
   input  logic [ADDR_W-1:0] rd_adr2,
   input  logic [ADDR_W-1:0] wr_adr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_en,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   output logic              wr_pending
);

   localparam int DEPTH = 2 ** ADDR_W;

   // Register contents after reset. R0 is forced to zero when it is hardwired,
   // so the array never holds a non-zero value there in that configuration.
   function automatic logic [DATA_W-1:0] reset_value(input int idx);
      logic [DATA_W-1:0] val;
      val = '0;
      if (idx == 0) begin
         val = (ZERO_R0 != 0) ? '0 : INIT_R0;
      end else if (idx == 1) begin
         val = INIT_R1;
      end
      return val;
   endfunction

   logic [DATA_W-1:0] mem_reg [DEPTH];

   logic              pend_valid_reg;
   logic [ADDR_W-1:0] pend_adr_reg;
   logic [DATA_W-1:0] pend_data_reg;

   // Writes to a hardwired R0 are dropped at capture time, so they never
   // raise wr_pending and can never appear on the bypass path.
   logic wr_accept;
   assign wr_accept = wr_en && !((ZERO_R0 != 0) && (wr_adr == '0));

   // Stage 1: capture the incoming write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_valid_reg <= 1'b0;
         pend_adr_reg   <= '0;
         pend_data_reg  <= '0;
      end else begin
         pend_valid_reg <= wr_accept;
         pend_adr_reg   <= wr_adr;
         pend_data_reg  <= wr_data;
      end
   end

   // Stage 2: commit the previously captured write. A reset while a write is
   // pending drops it, because the pending stage and the array clear together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= reset_value(i);
         end
      end else if (pend_valid_reg) begin
         mem_reg[pend_adr_reg] <= pend_data_reg;
      end
   end

   // Read ports. Only the registered pending stage feeds the mux; the live
   // wr_adr/wr_data never reach the read data combinationally.
   logic [ADDR_W-1:0] rd_adr_arr  [2];
   logic [DATA_W-1:0] rd_data_arr [2];

   assign rd_adr_arr[0] = rd_adr1;
   assign rd_adr_arr[1] = rd_adr2;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_rd_port
         logic zero_hit;
         logic byp_hit;

         assign zero_hit = (ZERO_R0 != 0) && (rd_adr_arr[gi] == '0);
         assign byp_hit  = (BYPASS != 0) && pend_valid_reg &&
                           (pend_adr_reg == rd_adr_arr[gi]);

         assign rd_data_arr[gi] = zero_hit ? '0 :
                                  byp_hit  ? pend_data_reg :
                                             mem_reg[rd_adr_arr[gi]];
      end
   endgenerate

   assign rd_data1   = rd_data_arr[0];
   assign rd_data2   = rd_data_arr[1];
   assign wr_pending = pend_valid_reg;

endmodule
